bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter that shares the single memory-mapped peripheral bus between the CPU data port (master 0) and a second bus master (master 1, the debug/loader port). The slave side of the peripheral bus carries the switches, buttons and LEDs. The arbiter sits between both masters and the slave and runs in the CPU clock domain. It serialises accesses into fixed 3-cycle transactions, grants in round-robin order, and returns read data with a one-cycle acknowledge pulse.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  synchronous reset, active-low
- m0_req  in  1  master 0 request; held until m0_ack
- m0_addr  in  ADDR_W  master 0 address
- m0_wen  in  1  master 0 write (1) / read (0)
- m0_wdata  in  DATA_W  master 0 write data
- m0_ack  out  1  one-cycle transaction-complete pulse
- m0_rdata  out  DATA_W  read data, valid while m0_ack=1
- m1_req, m1_addr, m1_wen, m1_wdata, m1_ack, m1_rdata: same as the m0 ports, for master 1
- s_addr  out  ADDR_W  slave address
- s_wen  out  1  slave write strobe
- s_wdata  out  DATA_W  slave write data
- s_rdata  in  DATA_W  slave read data; registered by the slave, valid the cycle after s_addr
- busy  out  1  high while state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, CAPTURE.
- **IDLE**
  - A master's request is eligible when its req=1 and its own ack is not high this cycle. This suppresses re-grant of a request that is still held during its ack cycle.
  - If both masters are eligible, grant the master not granted last (pointer `last`).
  - If one is eligible, grant it.
  - On grant: latch addr, wen and wdata into s_addr, s_wdata and an internal wen register; record the granted index in `cur`; set `last`=cur; go to ACCESS.
  - If none is eligible, stay in IDLE.
- **ACCESS**
  - s_wen = latched wen for this single cycle only; s_wen is 0 in every other state.
  - s_addr and s_wdata are held from IDLE through CAPTURE.
  - Unconditionally go to CAPTURE.
- **CAPTURE**
  - Register s_rdata into m{cur}_rdata.
  - Set m{cur}_ack=1 for the next cycle.
  - Go to IDLE.
- Writes also pass through CAPTURE. For a write, m_rdata holds whatever the slave returned; the master must ignore it.
- The non-granted master's rdata holds its previous value, and its ack stays 0.
- Dropping req after grant does not abort the transaction. It completes, and ack still pulses.
- Request inputs are sampled only in IDLE. Changes to addr/wen/wdata after grant are ignored.
- No timeout. The slave always responds in fixed latency.

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE, last=1 (master 0 wins the first tie), cur=0, s_addr=0, s_wdata=0, s_wen=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, busy=0.
  - Reset applied mid-transaction abandons it. A write in ACCESS is cut off because s_wen drops in the reset cycle, and no ack is issued.
- Transaction latency, with req sampled in IDLE at cycle T:
  - ACCESS in T+1; s_wen, if a write, is high only in T+1.
  - CAPTURE in T+2; slave data is valid in T+2.
  - ack and rdata valid in T+3.
- Throughput: one transaction per 3 cycles. The next grant can be sampled in T+3, which is IDLE concurrent with the ack.
- ack is exactly one cycle wide and is never asserted for both masters in the same cycle.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1,… A master waits at most one transaction (3 cycles) beyond its own turn.

## Test plan
- **Single read.** Reset, then m0_req=1, m0_addr=0xFFFFFC70, m0_wen=0; slave returns 0x00A5A5A5 in the cycle after ACCESS.
  - Expect s_addr=0xFFFFFC70 in T+1, m0_ack=1 with m0_rdata=0x00A5A5A5 in T+3, and m1_ack=0 throughout.
- **Single write.** m1 writes 0x00FFFFFF to 0xFFFFFC60.
  - Expect s_wen=1 for exactly one cycle (T+1) with s_wdata=0x00FFFFFF, and m1_ack pulses in T+3.
- **Simultaneous requests from reset.** Both masters hold req for 4 transactions each.
  - Expect grant order 0,1,0,1,0,1,0,1, acks at cycles T+3, T+6, T+9, …, and never both acks high together.
- **Ack-cycle hold.** m0 holds req one cycle past its ack, with m1 idle.
  - Expect no second transaction: busy=0 and s_wen=0 after the ack cycle.
  - Repeat with m0 back-to-back (req re-asserted with new addr after the ack): expect the next grant in the following IDLE and ack 4 cycles after the first.
- **Reset mid-write.** Assert rst_n=0 during ACCESS of an m0 write.
  - Expect s_wen=0 from that cycle, no m0_ack, all outputs at reset values, and m0 winning the next tie.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral bus.
// Each grant runs a fixed IDLE -> ACCESS -> CAPTURE sequence and ends with a one-cycle ack.
module bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_wen,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_wen,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wen,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE
    } state_t;

    state_t state;
    logic   last;
    logic   cur;
    logic   wen_q;
    logic   elig0;
    logic   elig1;
    logic   pick;

    // A request still held during its own ack cycle must not be re-granted.
    assign elig0 = m0_req & ~m0_ack;
    assign elig1 = m1_req & ~m1_ack;

    // Choose the winner: on a tie, the master not served last goes first.
    always_comb begin
        pick = 1'b0;
        if (elig0 && elig1) begin
            pick = ~last;
        end else if (elig1) begin
            pick = 1'b1;
        end
    end

    // The write strobe is only ever open during the single ACCESS cycle.
    assign s_wen = (state == ACCESS) & wen_q;
    assign busy  = (state != IDLE);

    // Transaction sequencer with registered bus and master-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            cur      <= 1'b0;
            wen_q    <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        cur     <= pick;
                        last    <= pick;
                        s_addr  <= pick ? m1_addr  : m0_addr;
                        s_wdata <= pick ? m1_wdata : m0_wdata;
                        wen_q   <= pick ? m1_wen   : m0_wen;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (cur) begin
                        m1_rdata <= s_rdata;
                        m1_ack   <= 1'b1;
                    end else begin
                        m0_rdata <= s_rdata;
                        m0_ack   <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a registered slave model.
// The slave returns 0x00A5A5A5 at 0xFFFFFC70 and the inverted address elsewhere.
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic          m0_wen = 1'b0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic          m1_wen = 1'b0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] s_addr;
    logic          s_wen;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata = '0;
    logic          busy;

    int checks = 0;
    int failures = 0;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .s_addr(s_addr), .s_wen(s_wen), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Slave: data registered, valid the cycle after the address.
    always @(posedge clk) begin
        s_rdata <= (s_addr == 32'hFFFFFC70) ? 32'h00A5A5A5 : ~s_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (s_wen !== 1'b0) begin failures++; $display("FAIL reset_s_wen got=%b exp=0", s_wen); end
        checks++; if (s_addr !== 32'h0) begin failures++; $display("FAIL reset_s_addr got=%h exp=0", s_addr); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b exp=00", {m0_ack, m1_ack}); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        m0_addr = 32'hFFFFFC70;
        m0_wen = 1'b0;
        m0_req = 1'b1;
        tick();
        checks++; if (s_addr !== 32'hFFFFFC70) begin failures++; $display("FAIL read_s_addr got=%h exp=fffffc70", s_addr); end
        checks++; if (s_wen !== 1'b0) begin failures++; $display("FAIL read_s_wen got=%b exp=0", s_wen); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL read_busy got=%b exp=1", busy); end
        checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL read_m1_ack_t1 got=%b exp=0", m1_ack); end
        tick();
        checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL read_early_ack got=%b exp=0", m0_ack); end
        tick();
        checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL read_ack got=%b exp=1", m0_ack); end
        checks++; if (m0_rdata !== 32'h00A5A5A5) begin failures++; $display("FAIL read_rdata got=%h exp=00a5a5a5", m0_rdata); end
        checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL read_m1_ack_t3 got=%b exp=0", m1_ack); end
        m0_req = 1'b0;
        tick();
        checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL read_ack_width got=%b exp=0", m0_ack); end
    endtask

    task automatic test_single_write();
        m1_addr = 32'hFFFFFC60;
        m1_wen = 1'b1;
        m1_wdata = 32'h00FFFFFF;
        m1_req = 1'b1;
        checks++; if (s_wen !== 1'b0) begin failures++; $display("FAIL write_s_wen_t0 got=%b exp=0", s_wen); end
        tick();
        checks++; if (s_wen !== 1'b1) begin failures++; $display("FAIL write_s_wen_t1 got=%b exp=1", s_wen); end
        checks++; if (s_wdata !== 32'h00FFFFFF) begin failures++; $display("FAIL write_s_wdata got=%h exp=00ffffff", s_wdata); end
        checks++; if (s_addr !== 32'hFFFFFC60) begin failures++; $display("FAIL write_s_addr got=%h exp=fffffc60", s_addr); end
        tick();
        checks++; if (s_wen !== 1'b0) begin failures++; $display("FAIL write_s_wen_t2 got=%b exp=0", s_wen); end
        checks++; if (s_wdata !== 32'h00FFFFFF) begin failures++; $display("FAIL write_wdata_hold got=%h exp=00ffffff", s_wdata); end
        tick();
        checks++; if (m1_ack !== 1'b1) begin failures++; $display("FAIL write_ack got=%b exp=1", m1_ack); end
        checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL write_m0_ack got=%b exp=0", m0_ack); end
        checks++; if (m1_rdata !== 32'h0000039F) begin failures++; $display("FAIL write_rdata got=%h exp=0000039f", m1_rdata); end
        checks++; if (m0_rdata !== 32'h00A5A5A5) begin failures++; $display("FAIL write_m0_rdata_hold got=%h exp=00a5a5a5", m0_rdata); end
        checks++; if (s_wen !== 1'b0) begin failures++; $display("FAIL write_s_wen_t3 got=%b exp=0", s_wen); end
        m1_req = 1'b0;
        m1_wen = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp;
        int n;
        test_reset();
        m0_addr = 32'h100;
        m1_addr = 32'h200;
        m0_wen = 1'b0;
        m1_wen = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            checks++; if (m0_ack && m1_ack) begin failures++; $display("FAIL rr_both_acks c=%0d got=11 exp=not both", c); end
            if (c % 3 == 1) begin
                n = c / 3;
                exp = (n % 2 == 1) ? 32'h200 + n / 2 : 32'h100 + n / 2;
                checks++; if (s_addr !== exp) begin failures++; $display("FAIL rr_grant n=%0d got=%h exp=%h", n, s_addr, exp); end
            end
            if (c % 3 != 0) begin
                checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL rr_stray_ack c=%0d got=%b exp=00", c, {m0_ack, m1_ack}); end
            end else begin
                n = c / 3 - 1;
                if (n % 2 == 0) begin
                    exp = ~(32'h100 + n / 2);
                    checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL rr_m0_ack n=%0d got=%b exp=1", n, m0_ack); end
                    checks++; if (m0_rdata !== exp) begin failures++; $display("FAIL rr_m0_rdata n=%0d got=%h exp=%h", n, m0_rdata, exp); end
                    m0_addr = m0_addr + 1;
                    if (n / 2 == 3) m0_req = 1'b0;
                end else begin
                    exp = ~(32'h200 + n / 2);
                    checks++; if (m1_ack !== 1'b1) begin failures++; $display("FAIL rr_m1_ack n=%0d got=%b exp=1", n, m1_ack); end
                    checks++; if (m1_rdata !== exp) begin failures++; $display("FAIL rr_m1_rdata n=%0d got=%h exp=%h", n, m1_rdata, exp); end
                    m1_addr = m1_addr + 1;
                    if (n / 2 == 3) m1_req = 1'b0;
                end
            end
        end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle_end got=%b exp=0", busy); end
    endtask

    task automatic test_ack_hold();
        m0_addr = 32'h300;
        m0_wen = 1'b1;
        m0_wdata = 32'hCAFE;
        m0_req = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL hold_ack got=%b exp=1", m0_ack); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy got=%b exp=0", busy); end
        checks++; if (s_wen !== 1'b0) begin failures++; $display("FAIL hold_s_wen got=%b exp=0", s_wen); end
        m0_req = 1'b0;
        m0_wen = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy2 got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        m0_addr = 32'h310;
        m0_req = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack1 got=%b exp=1", m0_ack); end
        checks++; if (m0_rdata !== 32'hFFFFFCEF) begin failures++; $display("FAIL b2b_rdata1 got=%h exp=fffffcef", m0_rdata); end
        m0_addr = 32'h320;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", busy); end
        tick();
        checks++; if (s_addr !== 32'h320) begin failures++; $display("FAIL b2b_s_addr got=%h exp=00000320", s_addr); end
        tick();
        checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL b2b_early got=%b exp=0", m0_ack); end
        tick();
        checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack2 got=%b exp=1", m0_ack); end
        checks++; if (m0_rdata !== 32'hFFFFFCDF) begin failures++; $display("FAIL b2b_rdata2 got=%h exp=fffffcdf", m0_rdata); end
        m0_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        m0_addr = 32'h40;
        m0_wen = 1'b1;
        m0_wdata = 32'h1234;
        m0_req = 1'b1;
        tick();
        checks++; if (s_wen !== 1'b1) begin failures++; $display("FAIL rst_mid_s_wen_pre got=%b exp=1", s_wen); end
        rst_n = 1'b0;
        m0_req = 1'b0;
        m0_wen = 1'b0;
        tick();
        checks++; if (s_wen !== 1'b0) begin failures++; $display("FAIL rst_mid_s_wen got=%b exp=0", s_wen); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if ({s_addr, s_wdata} !== 64'h0) begin failures++; $display("FAIL rst_mid_bus got=%h exp=0", {s_addr, s_wdata}); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin failures++; $display("FAIL rst_mid_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL rst_mid_no_ack got=%b exp=00", {m0_ack, m1_ack}); end
        m0_addr = 32'h50;
        m1_addr = 32'h60;
        m0_req = 1'b1;
        m1_req = 1'b1;
        tick();
        checks++; if (s_addr !== 32'h50) begin failures++; $display("FAIL rst_tie_grant got=%h exp=00000050", s_addr); end
        tick();
        tick();
        checks++; if ({m0_ack, m1_ack} !== 2'b10) begin failures++; $display("FAIL rst_tie_ack got=%b exp=10", {m0_ack, m1_ack}); end
        m0_req = 1'b0;
        tick();
        tick();
        tick();
        checks++; if ({m0_ack, m1_ack} !== 2'b01) begin failures++; $display("FAIL rst_m1_ack got=%b exp=01", {m0_ack, m1_ack}); end
        checks++; if (m1_rdata !== 32'hFFFFFF9F) begin failures++; $display("FAIL rst_m1_rdata got=%h exp=ffffff9f", m1_rdata); end
        m1_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_ack_hold();
        test_back_to_back();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
